// File: rtl/commit_monitor_pkg.sv
// Shared definitions for the retirement-stream commit monitor.
//   PC_WIDTH / CNT_WIDTH / TRACE_FIFO_DEPTH : default widths and FIFO depth
//   TRACE_* : bit positions of the flag fields inside a trace record, which is
//             laid out {pc, actual_npc, branch, taken, mispred} MSB first
//   resolve_kind_e : why the pending record is being resolved this cycle
package commit_monitor_pkg;

  localparam int PC_WIDTH         = 32;
  localparam int CNT_WIDTH        = 32;
  localparam int TRACE_FIFO_DEPTH = 8;

  localparam int TRACE_MISPRED    = 0;
  localparam int TRACE_TAKEN      = 1;
  localparam int TRACE_BRANCH     = 2;
  localparam int TRACE_NPC_LSB    = 3;

  typedef enum logic [1:0] {
    RES_NONE   = 2'd0,
    RES_COMMIT = 2'd1,
    RES_HALT   = 2'd2
  } resolve_kind_e;

endpackage

// File: rtl/commit_monitor_trace_fifo.sv
// trace_fifo: valid/ready trace buffer with a registered head output.
//   clk, rst : clock, asynchronous active-high reset
//   push, din : write request and record; accepted when not full, or when
//               full and a pop happens in the same cycle
//   pop       : remove the head; ignored while empty
//   full, empty : occupancy flags from pointer MSB/index compare
//   dout      : registered copy of the head entry
module trace_fifo #(
  parameter int WIDTH = 67,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wptr_r;
  logic [AW:0]      rptr_r;
  logic [WIDTH-1:0] dout_r;
  logic             pop_ok_s;
  logic             push_ok_s;
  logic [AW:0]      rptr_nx_s;
  logic [WIDTH-1:0] head_s;

  assign empty = (wptr_r == rptr_r);
  assign full  = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
  assign dout  = dout_r;

  // Acceptance and the head entry as it will look after this edge
  always_comb begin
    pop_ok_s  = pop && !empty;
    push_ok_s = push && (!full || pop_ok_s);
    rptr_nx_s = rptr_r + {{AW{1'b0}}, pop_ok_s};
    // The incoming record becomes the head when it lands in the slot the
    // read pointer will point at (FIFO empty after this cycle's pop).
    if (push_ok_s && (wptr_r[AW-1:0] == rptr_nx_s[AW-1:0])) begin
      head_s = din;
    end else begin
      head_s = mem_r[rptr_nx_s[AW-1:0]];
    end
  end

  // Storage, pointers and the registered head
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_r <= {(AW+1){1'b0}};
      rptr_r <= {(AW+1){1'b0}};
      dout_r <= {WIDTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      if (push_ok_s) begin
        mem_r[wptr_r[AW-1:0]] <= din;
      end
      wptr_r <= wptr_r + {{AW{1'b0}}, push_ok_s};
      rptr_r <= rptr_nx_s;
      dout_r <= head_s;
    end
  end

endmodule

// File: rtl/commit_monitor.sv
// commit_monitor: resolves each retired instruction's predicted next PC
// against the next retired PC, keeps saturating performance counters and
// buffers one trace record per resolved instruction for the host.
//   clk_i, rst            : clock, asynchronous active-high reset
//   commit_*_i            : retirement stream (valid, pc, predicted next pc,
//                           conditional-branch flag, taken flag)
//   halt_i                : resolve the pending record with no successor
//   clear_i               : synchronous zero of all counters
//   *_cnt_o               : saturating counters
//   trace_valid_o/data_o  : FIFO head, popped when trace_ready_i is high
module commit_monitor
  import commit_monitor_pkg::*;
#(
  parameter int PC_W       = PC_WIDTH,
  parameter int CNT_W      = CNT_WIDTH,
  parameter int FIFO_DEPTH = TRACE_FIFO_DEPTH
) (
  input  logic              clk_i,
  input  logic              rst,
  input  logic              commit_i,
  input  logic [PC_W-1:0]   commit_pc_i,
  input  logic [PC_W-1:0]   commit_pre_pc_i,
  input  logic              commit_branch_i,
  input  logic              commit_taken_i,
  input  logic              halt_i,
  input  logic              clear_i,
  output logic [CNT_W-1:0]  instr_cnt_o,
  output logic [CNT_W-1:0]  branch_cnt_o,
  output logic [CNT_W-1:0]  taken_cnt_o,
  output logic [CNT_W-1:0]  mispred_cnt_o,
  output logic [CNT_W-1:0]  br_mispred_cnt_o,
  output logic [CNT_W-1:0]  drop_cnt_o,
  output logic              trace_valid_o,
  output logic [2*PC_W+2:0] trace_data_o,
  input  logic              trace_ready_i
);

  localparam int TW = 2 * PC_W + 3;

  logic            pend_valid_r;
  logic [PC_W-1:0] pend_pc_r;
  logic [PC_W-1:0] pend_pre_r;
  logic            pend_br_r;
  logic            pend_tk_r;

  resolve_kind_e   res_kind_s;
  logic            res_s;
  logic [PC_W-1:0] npc_s;
  logic            mispred_s;
  logic [TW-1:0]   rec_s;
  logic            full_s;
  logic            empty_s;
  logic            pop_s;
  logic            drop_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                               input logic            inc);
    if (inc && (cnt != {CNT_W{1'b1}})) begin
      sat_inc = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      sat_inc = cnt;
    end
  endfunction

  // Decide whether and how the pending record resolves; a commit beats halt
  always_comb begin
    if (pend_valid_r && commit_i) begin
      res_kind_s = RES_COMMIT;
    end else if (pend_valid_r && halt_i) begin
      res_kind_s = RES_HALT;
    end else begin
      res_kind_s = RES_NONE;
    end
    case (res_kind_s)
      RES_COMMIT: begin
        res_s     = 1'b1;
        npc_s     = commit_pc_i;
        mispred_s = (pend_pre_r != commit_pc_i);
      end
      RES_HALT: begin
        // No successor exists, so the prediction is taken as correct.
        res_s     = 1'b1;
        npc_s     = pend_pre_r;
        mispred_s = 1'b0;
      end
      default: begin
        res_s     = 1'b0;
        npc_s     = pend_pre_r;
        mispred_s = 1'b0;
      end
    endcase
    rec_s                        = {TW{1'b0}};
    rec_s[TW-1 -: PC_W]          = pend_pc_r;
    rec_s[TRACE_NPC_LSB +: PC_W] = npc_s;
    rec_s[TRACE_BRANCH]          = pend_br_r;
    rec_s[TRACE_TAKEN]           = pend_tk_r;
    rec_s[TRACE_MISPRED]         = mispred_s;
  end

  assign pop_s         = trace_ready_i && !empty_s;
  assign drop_s        = res_s && full_s && !pop_s;
  assign trace_valid_o = !empty_s;

  // Pending record: load on every commit, retire on a halt without commit
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      pend_valid_r <= 1'b0;
      pend_pc_r    <= {PC_W{1'b0}};
      pend_pre_r   <= {PC_W{1'b0}};
      pend_br_r    <= 1'b0;
      pend_tk_r    <= 1'b0;
    end else if (commit_i) begin
      pend_valid_r <= 1'b1;
      pend_pc_r    <= commit_pc_i;
      pend_pre_r   <= commit_pre_pc_i;
      pend_br_r    <= commit_branch_i;
      pend_tk_r    <= commit_taken_i;
    end else if (halt_i) begin
      pend_valid_r <= 1'b0;
    end
  end

  // Saturating performance counters; clear discards same-cycle increments
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      instr_cnt_o      <= {CNT_W{1'b0}};
      branch_cnt_o     <= {CNT_W{1'b0}};
      taken_cnt_o      <= {CNT_W{1'b0}};
      mispred_cnt_o    <= {CNT_W{1'b0}};
      br_mispred_cnt_o <= {CNT_W{1'b0}};
      drop_cnt_o       <= {CNT_W{1'b0}};
    end else if (clear_i) begin
      instr_cnt_o      <= {CNT_W{1'b0}};
      branch_cnt_o     <= {CNT_W{1'b0}};
      taken_cnt_o      <= {CNT_W{1'b0}};
      mispred_cnt_o    <= {CNT_W{1'b0}};
      br_mispred_cnt_o <= {CNT_W{1'b0}};
      drop_cnt_o       <= {CNT_W{1'b0}};
    end else begin
      instr_cnt_o      <= sat_inc(instr_cnt_o, res_s);
      branch_cnt_o     <= sat_inc(branch_cnt_o, res_s && pend_br_r);
      taken_cnt_o      <= sat_inc(taken_cnt_o, res_s && pend_br_r && pend_tk_r);
      mispred_cnt_o    <= sat_inc(mispred_cnt_o, res_s && mispred_s);
      br_mispred_cnt_o <= sat_inc(br_mispred_cnt_o, res_s && mispred_s && pend_br_r);
      drop_cnt_o       <= sat_inc(drop_cnt_o, drop_s);
    end
  end

  trace_fifo #(
    .WIDTH(TW),
    .DEPTH(FIFO_DEPTH)
  ) u_trace_fifo (
    .clk  (clk_i),
    .rst  (rst),
    .push (res_s),
    .din  (rec_s),
    .pop  (pop_s),
    .full (full_s),
    .empty(empty_s),
    .dout (trace_data_o)
  );

endmodule
